// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter in front of a shared combinational RV32 ALU
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   req_valid/req_ready[1:0]   request handshake per port (0: execute, 1: branch/AGU)
//   req_i_en/b_en/funct3/funct7/rs1/rs2/tag[k]   op fields per port
//   resp_valid/resp_ready[1:0] response handshake per port
//   resp_rd, resp_tag          shared result and echoed tag, qualified by resp_valid[k]
//   alu_i_en..alu_rs2          registered operands to the ALU
//   alu_rd                     ALU combinational result
//
// Configuration
//   ALU_ARB_FIXED_PRIO_EN      port 0 always wins a simultaneous request (no last_grant);
//                              default build is round-robin.
module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_i_en,
    input  logic [1:0]            req_b_en,
    input  logic [1:0][2:0]       req_funct3,
    input  logic [1:0][6:0]       req_funct7,
    input  logic [1:0][31:0]      req_rs1,
    input  logic [1:0][31:0]      req_rs2,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [31:0]           resp_rd,
    output logic [TAG_W-1:0]      resp_tag,
    output logic                  alu_i_en,
    output logic                  alu_b_en,
    output logic [2:0]            alu_funct3,
    output logic [6:0]            alu_funct7,
    output logic [31:0]           alu_rs1,
    output logic [31:0]           alu_rs2,
    input  logic [31:0]           alu_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               grant;
    logic               accept;
    logic               op_id;
    logic               op_i_en;
    logic               op_b_en;
    logic [2:0]         op_funct3;
    logic [6:0]         op_funct7;
    logic [31:0]        op_rs1;
    logic [31:0]        op_rs2;
    logic [TAG_W-1:0]   op_tag;
    logic [31:0]        result;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic               last_grant;
`endif

    always_comb begin
        grant      = 1'b0;
        accept     = 1'b0;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        state_next = state;

        case (req_valid)
            2'b10:   grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant = 1'b0;
`else
            // Contention: the port that did not win last time goes first.
            2'b11:   grant = ~last_grant;
`endif
            default: grant = 1'b0;
        endcase

        // Handshake outputs are forced low while reset is asserted.
        accept = rst_n && (state == IDLE) && (req_valid != 2'b00);
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        if (rst_n && (state == RESP)) begin
            resp_valid[op_id] = 1'b1;
        end

        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready[op_id]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_id      <= 1'b0;
            op_i_en    <= 1'b0;
            op_b_en    <= 1'b0;
            op_funct3  <= 3'd0;
            op_funct7  <= 7'd0;
            op_rs1     <= 32'd0;
            op_rs2     <= 32'd0;
            op_tag     <= '0;
            result     <= 32'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                op_id     <= grant;
                op_i_en   <= req_i_en[grant];
                op_b_en   <= req_b_en[grant];
                op_funct3 <= req_funct3[grant];
                op_funct7 <= req_funct7[grant];
                op_rs1    <= req_rs1[grant];
                op_rs2    <= req_rs2[grant];
                op_tag    <= req_tag[grant];
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant <= grant;
`endif
            end
            if (state == EXEC) begin
                result <= alu_rd;
            end
        end
    end

    assign alu_i_en   = op_i_en;
    assign alu_b_en   = op_b_en;
    assign alu_funct3 = op_funct3;
    assign alu_funct7 = op_funct7;
    assign alu_rs1    = op_rs1;
    assign alu_rs2    = op_rs2;
    assign resp_rd    = result;
    assign resp_tag   = op_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural RV32 ALU
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_i_en;
    logic [1:0]            req_b_en;
    logic [1:0][2:0]       req_funct3;
    logic [1:0][6:0]       req_funct7;
    logic [1:0][31:0]      req_rs1;
    logic [1:0][31:0]      req_rs2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [1:0]            resp_valid;
    logic [1:0]            resp_ready;
    logic [31:0]           resp_rd;
    logic [TAG_W-1:0]      resp_tag;
    logic                  alu_i_en;
    logic                  alu_b_en;
    logic [2:0]            alu_funct3;
    logic [6:0]            alu_funct7;
    logic [31:0]           alu_rs1;
    logic [31:0]           alu_rs2;
    logic [31:0]           alu_rd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_i_en   (req_i_en),
        .req_b_en   (req_b_en),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rd    (resp_rd),
        .resp_tag   (resp_tag),
        .alu_i_en   (alu_i_en),
        .alu_b_en   (alu_b_en),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_rd     (alu_rd)
    );

    // Stand-in for the shared ALU instance.
    always_comb begin
        alu_rd = 32'd0;
        if (alu_b_en) begin
            alu_rd = alu_rs1 + alu_rs2;
        end else begin
            case (alu_funct3)
                3'd0: alu_rd = (!alu_i_en && alu_funct7[5]) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
                3'd1: alu_rd = alu_rs1 << alu_rs2[4:0];
                3'd2: alu_rd = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
                3'd3: alu_rd = {31'd0, alu_rs1 < alu_rs2};
                3'd4: alu_rd = alu_rs1 ^ alu_rs2;
                3'd5: alu_rd = alu_funct7[5] ? $unsigned($signed(alu_rs1) >>> alu_rs2[4:0])
                                             : alu_rs1 >> alu_rs2[4:0];
                3'd6: alu_rd = alu_rs1 | alu_rs2;
                default: alu_rd = alu_rs1 & alu_rs2;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic i_en, input logic b_en, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
        req_i_en[p]   = i_en;
        req_b_en[p]   = b_en;
        req_funct3[p] = f3;
        req_funct7[p] = f7;
        req_rs1[p]    = a;
        req_rs2[p]    = b;
        req_tag[p]    = t;
        req_valid[p]  = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) at negedges for req_ready; returns the granted port.
    task automatic wait_ready(output int g);
        int n;
        g = 0;
        for (n = 0; n < 10; n++) begin
            #1;
            if (req_ready != 2'b00) break;
            cycle();
        end
        if (n == 10) check("ready_timeout", 32'd0, 32'd1);
        g = req_ready[1] ? 1 : 0;
    endtask

    initial begin
        int g;
        int seen;
        int exp_g;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_i_en   = '0;
        req_b_en   = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        resp_ready = 2'b11;

        // Reset state: handshake outputs low even with requests present.
        @(negedge clk);
        req_valid = 2'b11;
        cycle();
        #1;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        check("rst_resp_rd", resp_rd, 32'd0);
        check("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
        do_reset();

        // 1: single add on port 0, latency T -> T+2.
        set_req(0, 0, 0, 3'd0, 7'd0, 32'd5, 32'd3, 4'd2);
        #1 check("t1_ready", {30'd0, req_ready}, 32'd1);
        cycle();
        req_valid = 2'b00;
        #1 check("t1_exec_rv", {30'd0, resp_valid}, 32'd0);
        check("t1_alu_rs1", alu_rs1, 32'd5);
        cycle();
        #1 check("t1_rv", {30'd0, resp_valid}, 32'd1);
        check("t1_rd", resp_rd, 32'd8);
        check("t1_tag", {28'd0, resp_tag}, 32'd2);
        cycle();
        #1 check("t1_idle_rv", {30'd0, resp_valid}, 32'd0);

        // 2: simultaneous after reset; port 0 first, port 1 in the next IDLE cycle.
        do_reset();
        set_req(0, 0, 0, 3'd0, 7'h20, 32'd10, 32'd3, 4'd1);
        set_req(1, 0, 1, 3'd0, 7'd0, 32'h100, 32'h20, 4'd3);
        #1 check("t2_ready0", {30'd0, req_ready}, 32'd1);
        cycle();
        req_valid[0] = 1'b0;
        #1 check("t2_exec_ready", {30'd0, req_ready}, 32'd0);
        cycle();
        #1 check("t2_rv0", {30'd0, resp_valid}, 32'd1);
        check("t2_rd0", resp_rd, 32'd7);
        check("t2_resp_ready_hold", {30'd0, req_ready}, 32'd0);
        cycle();
        #1 check("t2_ready1", {30'd0, req_ready}, 32'd2);
        cycle();
        req_valid = 2'b00;
        cycle();
        #1 check("t2_rv1", {30'd0, resp_valid}, 32'd2);
        check("t2_rd1", resp_rd, 32'h120);
        check("t2_tag1", {28'd0, resp_tag}, 32'd3);
        cycle();

        // 3 (and 6 under fixed priority): continuous double requests.
        set_req(0, 0, 0, 3'd4, 7'd0, 32'hF0F0, 32'h0FF0, 4'h6);
        set_req(1, 1, 0, 3'd7, 7'd0, 32'h1234, 32'hFF, 4'h7);
        for (int k = 0; k < 6; k++) begin
            wait_ready(g);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 2;
`endif
            check("t3_grant", g, exp_g);
            cycle();
            cycle();
            #1 check("t3_rv", {30'd0, resp_valid}, 32'd1 << g);
            check("t3_rd", resp_rd, (g == 1) ? 32'h34 : 32'hFF00);
            check("t3_tag", {28'd0, resp_tag}, (g == 1) ? 32'h7 : 32'h6);
            cycle();
        end
        req_valid[0] = 1'b0;
        #1 check("t3_p1_after_drop", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        cycle();

        // 4: response back-pressure; non-granted resp_ready is ignored.
        do_reset();
        resp_ready = 2'b10;
        set_req(0, 0, 0, 3'd6, 7'd0, 32'hA0, 32'h0B, 4'd5);
        cycle();
        req_valid = 2'b00;
        set_req(1, 0, 0, 3'd0, 7'd0, 32'd1, 32'd1, 4'd9);
        cycle();
        for (int k = 0; k < 4; k++) begin
            #1 check("t4_rv_hold", {30'd0, resp_valid}, 32'd1);
            check("t4_rd_hold", resp_rd, 32'hAB);
            check("t4_tag_hold", {28'd0, resp_tag}, 32'd5);
            check("t4_ready_hold", {30'd0, req_ready}, 32'd0);
            cycle();
        end
        resp_ready = 2'b11;
        #1 check("t4_rv_release", {30'd0, resp_valid}, 32'd1);
        cycle();
        #1 check("t4_done_rv", {30'd0, resp_valid}, 32'd0);
        check("t4_done_ready", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        cycle();

        // 5: reset mid-EXEC drops the op; port 0 wins afterwards.
        set_req(0, 0, 0, 3'd5, 7'h20, 32'h80000000, 32'd4, 4'd4);
        #1 check("t5_ready", {30'd0, req_ready}, 32'd1);
        cycle();
        req_valid = 2'b00;
        #1 check("t5_exec_rs1", alu_rs1, 32'h80000000);
        rst_n = 1'b0;
        cycle();
        #1 check("t5_rst_rv", {30'd0, resp_valid}, 32'd0);
        check("t5_rst_rs1", alu_rs1, 32'd0);
        check("t5_rst_rd", resp_rd, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            #1 if (resp_valid != 2'b00) seen++;
        end
        check("t5_no_resp", seen, 32'd0);
        set_req(0, 0, 0, 3'd0, 7'd0, 32'd20, 32'd22, 4'd1);
        set_req(1, 0, 0, 3'd0, 7'd0, 32'd1, 32'd2, 4'd2);
        #1 check("t5_p0_wins", {30'd0, req_ready}, 32'd1);
        cycle();
        req_valid = 2'b00;
        cycle();
        #1 check("t5_rd", resp_rd, 32'd42);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
